// File: rtl/sap_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sap_control_sequencer
// Description : T-state sequencer and opcode decoder producing one-hot control
//               strobes for the 8-bit bus CPU, with run/step/halt control.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry,
  input  logic       zero,
  input  logic       run,
  input  logic       step,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_store,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic       instr_done,
  output logic [2:0] tstate
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [3:0] c_OP_LDA = 4'h1;
  localparam logic [3:0] c_OP_ADD = 4'h2;
  localparam logic [3:0] c_OP_SUB = 4'h3;
  localparam logic [3:0] c_OP_STA = 4'h4;
  localparam logic [3:0] c_OP_LDI = 4'h5;
  localparam logic [3:0] c_OP_JMP = 4'h6;
  localparam logic [3:0] c_OP_JC  = 4'h7;
  localparam logic [3:0] c_OP_JZ  = 4'h8;
  localparam logic [3:0] c_OP_OUT = 4'hE;
  localparam logic [3:0] c_OP_HLT = 4'hF;

  state_t r_state;
  state_t w_next;
  logic   w_done;
  logic   w_halt_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= run ? S_T0 : S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_out    = 1'b0;
    ram_store  = 1'b0;
    ir_load    = 1'b0;
    ir_out     = 1'b0;
    a_load     = 1'b0;
    a_out      = 1'b0;
    b_load     = 1'b0;
    alu_out    = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halted     = 1'b0;
    tstate     = 3'd0;
    w_done     = 1'b0;
    w_halt_req = 1'b0;
    w_next     = r_state;

    case (r_state)
      S_IDLE: begin
        if (run || step) w_next = S_T0;
      end
      S_T0: begin
        tstate   = 3'd0;
        pc_out   = 1'b1;
        mar_load = 1'b1;
        w_next   = S_T1;
      end
      S_T1: begin
        tstate  = 3'd1;
        ram_out = 1'b1;
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        w_next  = S_T2;
      end
      S_T2: begin
        tstate = 3'd2;
        case (opcode)
          c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
            w_next   = S_T3;
          end
          c_OP_LDI: begin
            ir_out = 1'b1;
            a_load = 1'b1;
            w_done = 1'b1;
          end
          c_OP_JMP: begin
            ir_out  = 1'b1;
            pc_load = 1'b1;
            w_done  = 1'b1;
          end
          c_OP_JC: begin
            ir_out  = carry;
            pc_load = carry;
            w_done  = 1'b1;
          end
          c_OP_JZ: begin
            ir_out  = zero;
            pc_load = zero;
            w_done  = 1'b1;
          end
          c_OP_OUT: begin
            a_out    = 1'b1;
            out_load = 1'b1;
            w_done   = 1'b1;
          end
          c_OP_HLT: begin
            w_done     = 1'b1;
            w_halt_req = 1'b1;
          end
          default: begin
            w_done = 1'b1;
          end
        endcase
      end
      S_T3: begin
        tstate = 3'd3;
        case (opcode)
          c_OP_LDA: begin
            ram_out = 1'b1;
            a_load  = 1'b1;
            w_done  = 1'b1;
          end
          c_OP_ADD, c_OP_SUB: begin
            ram_out = 1'b1;
            b_load  = 1'b1;
            w_next  = S_T4;
          end
          c_OP_STA: begin
            a_out     = 1'b1;
            ram_store = 1'b1;
            w_done    = 1'b1;
          end
          // Opcode changed under a live instruction: close it out cleanly.
          default: begin
            w_done = 1'b1;
          end
        endcase
      end
      S_T4: begin
        tstate = 3'd4;
        w_done = 1'b1;
        if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
          alu_out    = 1'b1;
          a_load     = 1'b1;
          flags_load = 1'b1;
          alu_sub    = (opcode == c_OP_SUB);
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if (w_done) begin
      if (w_halt_req) w_next = S_HALT;
      else            w_next = run ? S_T0 : S_IDLE;
    end

    // Reset holds every observable output low regardless of state.
    if (!rst) begin
      pc_out     = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      mar_load   = 1'b0;
      ram_out    = 1'b0;
      ram_store  = 1'b0;
      ir_load    = 1'b0;
      ir_out     = 1'b0;
      a_load     = 1'b0;
      a_out      = 1'b0;
      b_load     = 1'b0;
      alu_out    = 1'b0;
      alu_sub    = 1'b0;
      flags_load = 1'b0;
      out_load   = 1'b0;
      halted     = 1'b0;
      tstate     = 3'd0;
      w_done     = 1'b0;
    end
  end

  assign instr_done = w_done;

endmodule
`default_nettype wire

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Microcoded control sequencer for the 8-bit bus CPU. It steps a T-state counter through fetch and execute micro-steps and decodes the instruction-register opcode into one-hot control strobes for the PC, the memory block (MAR load, RAM out, RAM store), the A/B registers, the ALU, the flags register and the output register. It also provides run/single-step control and halt.

## Interface
Parameters:
- none. Opcode map and micro-step table are fixed by this spec.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- opcode  in  4  IR[7:4], the current instruction opcode
- carry  in  1  registered carry flag from the flags register
- zero  in  1  registered zero flag from the flags register
- run  in  1  1 = free-run; 0 = pause at instruction boundary
- step  in  1  one-cycle pulse; starts one instruction while paused
- pc_out, pc_inc, pc_load  out  1 each  PC drives bus / increments / loads from bus
- mar_load  out  1  memory MAR loads bus[3:0]
- ram_out  out  1  RAM word at MAR drives bus
- ram_store  out  1  RAM[MAR] written from bus
- ir_load, ir_out  out  1 each  IR loads bus / drives IR[3:0] zero-extended onto bus
- a_load, a_out, b_load  out  1 each  register strobes
- alu_out, alu_sub, flags_load  out  1 each  ALU drives bus / subtract select / flags capture
- out_load  out  1  output register loads bus
- halted  out  1  CPU halted
- instr_done  out  1  one-cycle pulse on the final micro-step of each instruction
- tstate  out  3  current T-state (0-4), for debug

## Operation
- States: IDLE (paused at T0), T0, T1, T2, T3, T4, HALT. The 3-bit counter is tstate; IDLE and HALT are flags on top of it.
- Fetch, common to all opcodes:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute: opcode is sampled combinationally from T2 onward.
  - 0 NOP: T2: no strobes; end.
  - 1 LDA: T2: ir_out, mar_load. T3: ram_out, a_load; end.
  - 2 ADD: T2: ir_out, mar_load. T3: ram_out, b_load. T4: alu_out, a_load, flags_load; end.
  - 3 SUB: as ADD, with alu_sub also asserted in T4.
  - 4 STA: T2: ir_out, mar_load. T3: a_out, ram_store; end.
  - 5 LDI: T2: ir_out, a_load; end.
  - 6 JMP: T2: ir_out, pc_load; end.
  - 7 JC, 8 JZ: T2: ir_out and pc_load only if carry (JC) or zero (JZ) is 1; end either way.
  - E OUT: T2: a_out, out_load; end.
  - F HLT: T2: no strobes; end; next state HALT.
  - 9-D undefined: behave exactly as NOP.
- End step:
  - instr_done = 1 in that cycle.
  - Next state is T0 if run = 1, otherwise IDLE. HLT always goes to HALT.
- IDLE:
  - All strobes 0.
  - Leaves to T0 on the cycle after run = 1 or step = 1.
  - step is ignored outside IDLE.
- HALT:
  - All strobes 0, halted = 1.
  - Exit only via rst.
- Invariant: at most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is asserted in any cycle.

## Timing
- Reset (rst = 0 at a clk edge):
  - Next state is IDLE if run = 0, else T0.
  - While rst = 0, every control output, halted and instr_done are forced to 0, and tstate reads 0.
  - Reset mid-instruction abandons the instruction; no partial strobes occur after the reset edge.
- Control outputs are combinational decode of (state, opcode, flags), valid for the whole cycle. Downstream registers act on the following rising edge.
- Instruction length in clocks:
  - NOP, LDI, JMP, JC, JZ, OUT, HLT: 3.
  - LDA, STA: 4.
  - ADD, SUB: 5.
- Back-to-back: with run = 1, the cycle after instr_done is T0 of the next instruction, with no bubble.
- run is evaluated only on the end step. Dropping run mid-instruction completes that instruction, then enters IDLE.
- step together with run = 0: exactly one instruction executes, then the sequencer returns to IDLE.
- Simultaneous run = 1 and step = 1 in IDLE: free-run; step has no extra effect.
- JC/JZ use the flag values present in T2. A flags_load in the immediately preceding ADD/SUB T4 is already visible by then.

## Test plan
- Reset with run = 1: hold rst = 0 for 3 cycles, then release -> tstate = 0, first cycle asserts exactly pc_out + mar_load, all other outputs 0.
- Free-run of LDA, ADD, STA, HLT -> strobe sequence matches the table per cycle; instr_done at cycles 3, 8, 12 and 15 after reset release (LDA 4 + ADD 5 + STA 4 + HLT 3 clocks); halted = 1 from cycle 16 onward and remains 1 for 20 more cycles.
- JC with carry = 0, then carry = 1 -> pc_load absent, then present in T2 with ir_out; both instructions take 3 cycles.
- run = 0 after reset, step pulsed once with opcode = 2 -> exactly 5 active cycles with one instr_done, then IDLE with all strobes 0; no further activity without another step.
- Assert rst = 0 during T3 of ADD -> no alu_out/a_load strobe follows; restart fetch at T0.
- Opcodes 9-D -> identical to NOP: 3 cycles, no strobes in T2. Every cycle of every test checks the single-bus-driver invariant.
